// File: rtl/uart_tx.sv
// 8-bit UART transmitter fed from an FWFT FIFO; bit timing comes from an external baud tick.
// Frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx #(
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       CLK288MHZ,
    input  logic       reset,
    input  logic       tick,
    output logic       baudReset,
    input  logic [7:0] fifoData,
    input  logic       fifoEmpty,
    output logic       readEn,
    output logic       uart_txd_in,
    output logic       busy
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e     r_state, w_state_d;
    logic [7:0] r_shift, w_shift_d;
    logic [7:0] r_data, w_data_d;
    logic [2:0] r_bit_cnt, w_bit_cnt_d;
    logic       r_stop_cnt, w_stop_cnt_d;
    logic       r_txd, w_txd_d;
    logic       r_read_en, w_read_en_d;
    logic       r_baud_reset, w_baud_reset_d;
    logic       r_busy, w_busy_d;

    logic w_tick, w_last_stop, w_par_bit, w_load;

    // The load cycle restarts baudGen, so any tick seen then belongs to the old phase.
    assign w_tick      = tick & ~r_read_en;
    assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
    assign w_par_bit   = (PARITY == 1) ? ~^r_data : ^r_data;
    assign w_load      = ~fifoEmpty &
                         ((r_state == StIdle) | ((r_state == StStop) & w_tick & w_last_stop));

    always_ff @(posedge CLK288MHZ) begin
        if (reset) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_data       <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= '0;
            r_txd        <= 1'b1;
            r_read_en    <= 1'b0;
            r_baud_reset <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_shift      <= w_shift_d;
            r_data       <= w_data_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_stop_cnt   <= w_stop_cnt_d;
            r_txd        <= w_txd_d;
            r_read_en    <= w_read_en_d;
            r_baud_reset <= w_baud_reset_d;
            r_busy       <= w_busy_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (!fifoEmpty) w_state_d = StStart;
            StStart:  if (w_tick) w_state_d = StData;
            StData: begin
                if (w_tick && (r_bit_cnt == 3'd7)) begin
                    w_state_d = (PARITY != 0) ? StParity : StStop;
                end
            end
            StParity: if (w_tick) w_state_d = StStop;
            StStop: begin
                if (w_tick && w_last_stop) w_state_d = fifoEmpty ? StIdle : StStart;
            end
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_shift_d      = r_shift;
        w_data_d       = r_data;
        w_bit_cnt_d    = r_bit_cnt;
        w_stop_cnt_d   = r_stop_cnt;
        w_txd_d        = r_txd;
        w_busy_d       = r_busy;
        w_read_en_d    = 1'b0;
        w_baud_reset_d = 1'b0;
        if (w_load) begin
            w_shift_d      = fifoData;
            w_data_d       = fifoData;
            w_bit_cnt_d    = '0;
            w_stop_cnt_d   = '0;
            w_txd_d        = 1'b0;
            w_busy_d       = 1'b1;
            w_read_en_d    = 1'b1;
            w_baud_reset_d = 1'b1;
        end else begin
            unique case (r_state)
                StIdle: w_txd_d = 1'b1;
                StStart: if (w_tick) w_txd_d = r_shift[0];
                StData: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_txd_d      = (PARITY != 0) ? w_par_bit : 1'b1;
                            w_stop_cnt_d = '0;
                        end else begin
                            w_shift_d   = r_shift >> 1;
                            w_txd_d     = r_shift[1];
                            w_bit_cnt_d = r_bit_cnt + 3'd1;
                        end
                    end
                end
                StParity: if (w_tick) w_txd_d = 1'b1;
                StStop: begin
                    if (w_tick) begin
                        if (w_last_stop) w_busy_d = 1'b0;
                        else w_stop_cnt_d = r_stop_cnt + 1'b1;
                    end
                end
                default: w_txd_d = 1'b1;
            endcase
        end
    end

    assign uart_txd_in = r_txd;
    assign readEn      = r_read_en;
    assign baudReset   = r_baud_reset;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parity/stop configurations, each with its own
// FIFO model, baudGen model and per-bit line monitor.
module tb_uart_tx;

    localparam int N       = 4;
    localparam int BIT_CYC = 48;
    localparam int PAR_CFG  [N] = '{0, 2, 1, 0};
    localparam int STOP_CFG [N] = '{1, 1, 1, 2};

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] tick, baud_reset, fifo_empty, read_en, txd, busy;
    logic [7:0] fifo_data [N];
    logic [7:0] fifo_mem  [N][16];
    logic [7:0] sb_q      [N][$];
    logic [N-1:0] prev_re;
    int wr_ptr [N], rd_ptr [N], bcnt [N];
    int re_cnt [N], br_cnt [N], re_bad [N], gap [N], end_cyc [N];
    int cyc;
    int n_chk, n_err;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            fifo_data[i]  = fifo_mem[i][rd_ptr[i][3:0]];
            tick[i]       = (bcnt[i] == BIT_CYC - 1);
        end
    end

    // FIFO pops, baudGen phase and readEn/baudReset protocol bookkeeping.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_re <= read_en;
        for (int i = 0; i < N; i++) begin
            if (baud_reset[i]) bcnt[i] <= 1;
            else if (bcnt[i] == BIT_CYC - 1) bcnt[i] <= 0;
            else bcnt[i] <= bcnt[i] + 1;
            if (read_en[i] && !fifo_empty[i]) rd_ptr[i] <= rd_ptr[i] + 1;
            if (read_en[i]) re_cnt[i] <= re_cnt[i] + 1;
            if (baud_reset[i]) br_cnt[i] <= br_cnt[i] + 1;
            if ((read_en[i] && (fifo_empty[i] || prev_re[i])) || (read_en[i] != baud_reset[i]))
                re_bad[i] <= re_bad[i] + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int idx);
        return 9 + ((PAR_CFG[idx] != 0) ? 1 : 0) + STOP_CFG[idx];
    endfunction

    function automatic logic exp_bit(input int idx, input logic [7:0] b, input int k);
        int ones = 0;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if ((PAR_CFG[idx] != 0) && (k == 9)) begin
            for (int j = 0; j < 8; j++) if (b[j]) ones++;
            // Even mode makes the total count of ones even, odd mode makes it odd.
            if (PAR_CFG[idx] == 2) return (ones % 2) == 1;
            return (ones % 2) == 0;
        end
        return 1'b1;
    endfunction

    task automatic push_byte(input int idx, input logic [7:0] b);
        fifo_mem[idx][wr_ptr[idx][3:0]] = b;
        wr_ptr[idx] = wr_ptr[idx] + 1;
        sb_q[idx].push_back(b);
    endtask

    task automatic mon_frame(input int idx);
        logic [7:0] b;
        logic       e;
        int         nbad;
        int         start;
        bit         aborted = 0;
        do @(negedge clk); while (txd[idx] !== 1'b0 || rst);
        start = cyc;
        if (sb_q[idx].size() == 0) begin
            chk($sformatf("u%0d_unexpected_frame", idx), 1, 0);
            b = 8'h00;
        end else begin
            b = sb_q[idx].pop_front();
        end
        gap[idx] = start - end_cyc[idx];
        for (int k = 0; k < frame_len(idx); k++) begin
            nbad = 0;
            e    = exp_bit(idx, b, k);
            for (int c = 0; c < BIT_CYC; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (rst) begin
                    aborted = 1;
                    break;
                end
                if (txd[idx] !== e) nbad++;
                if (busy[idx] !== 1'b1) nbad++;
            end
            if (aborted) break;
            chk($sformatf("u%0d_byte%02h_bit%0d", idx, b, k), nbad, 0);
        end
        end_cyc[idx] = cyc;
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx #(
            .PARITY   (PAR_CFG[g]),
            .STOP_BITS(STOP_CFG[g])
        ) u_dut (
            .CLK288MHZ  (clk),
            .reset      (rst),
            .tick       (tick[g]),
            .baudReset  (baud_reset[g]),
            .fifoData   (fifo_data[g]),
            .fifoEmpty  (fifo_empty[g]),
            .readEn     (read_en[g]),
            .uart_txd_in(txd[g]),
            .busy       (busy[g])
        );
        initial forever mon_frame(g);
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((busy != '0) || (fifo_empty != '1)) && (n < budget));
        chk("idle_wait_timeout", (n >= budget) ? 1 : 0, 0);
    endtask

    initial begin
        int snap_re [N];
        int snap_br [N];
        int low [N];
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d_rst_txd", i), int'(txd[i]), 1);
            chk($sformatf("u%0d_rst_busy", i), int'(busy[i]), 0);
            chk($sformatf("u%0d_rst_readen", i), int'(read_en[i]), 0);
            chk($sformatf("u%0d_rst_baudrst", i), int'(baud_reset[i]), 0);
        end
        #1 rst = 1'b0;

        // Single frames: 0x55 plain, 0x07 even and odd parity, 0xFF with two stop bits.
        @(negedge clk);
        #1;
        push_byte(0, 8'h55);
        push_byte(1, 8'h07);
        push_byte(2, 8'h07);
        push_byte(3, 8'hFF);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d_lat_txd", i), int'(txd[i]), 0);
            chk($sformatf("u%0d_lat_readen", i), int'(read_en[i]), 1);
            chk($sformatf("u%0d_lat_baudrst", i), int'(baud_reset[i]), 1);
            chk($sformatf("u%0d_lat_busy", i), int'(busy[i]), 1);
        end
        wait_idle(2000);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d_single_idle_txd", i), int'(txd[i]), 1);
            chk($sformatf("u%0d_single_readen_cnt", i), re_cnt[i], 1);
            chk($sformatf("u%0d_single_baudrst_cnt", i), br_cnt[i], 1);
        end

        // Back-to-back frames, one queued up front and one queued mid-frame.
        #1;
        push_byte(0, 8'hA5);
        push_byte(0, 8'h3C);
        push_byte(3, 8'hFF);
        repeat (200) @(negedge clk);
        #1 push_byte(3, 8'h5A);
        wait_idle(3000);
        chk("u0_b2b_gap", gap[0], 1);
        chk("u3_b2b_gap", gap[3], 1);
        chk("u0_b2b_readen_cnt", re_cnt[0], 3);
        chk("u3_b2b_readen_cnt", re_cnt[3], 3);

        // Reset during data bit 3 of 0x00.
        #1 push_byte(0, 8'h00);
        repeat (1 + 4 * BIT_CYC + 20) @(negedge clk);
        chk("u0_pre_rst_busy", int'(busy[0]), 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("u0_midrst_txd", int'(txd[0]), 1);
        chk("u0_midrst_busy", int'(busy[0]), 0);
        chk("u0_midrst_readen", int'(read_en[0]), 0);
        #1 rst = 1'b0;
        snap_re[0] = re_cnt[0];
        low[0] = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd[0] == 1'b0) low[0]++;
        end
        chk("u0_postrst_low_cycles", low[0], 0);
        chk("u0_postrst_readen_cnt", re_cnt[0], snap_re[0]);

        // Empty FIFO with free-running ticks.
        for (int i = 0; i < N; i++) begin
            snap_re[i] = re_cnt[i];
            snap_br[i] = br_cnt[i];
            low[i]     = 0;
        end
        repeat (1000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (txd[i] == 1'b0 || busy[i] == 1'b1) low[i]++;
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d_empty_active_cycles", i), low[i], 0);
            chk($sformatf("u%0d_empty_readen_cnt", i), re_cnt[i], snap_re[i]);
            chk($sformatf("u%0d_empty_baudrst_cnt", i), br_cnt[i], snap_br[i]);
            chk($sformatf("u%0d_readen_protocol_viol", i), re_bad[i], 0);
            chk($sformatf("u%0d_sb_leftover", i), sb_q[i].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
